// File: rtl/slot_game_pkg.sv
// Shared constants for the slot/code-lock game core: FSM state codes,
// default display words and the win counter width.
package slot_game_pkg;

    // FSM state encoding kept as plain constants so legacy code can decode it.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SPIN   = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_WIN    = 3'd3;
    localparam logic [2:0] ST_LOSE   = 3'd4;
    localparam logic [2:0] ST_LOCKED = 3'd5;

    // Display words for the default 4-reel, 4-bit-digit board ("bEd" / "LOSE").
    localparam logic [15:0] WIN_WORD_DEFAULT  = 16'h0BED;
    localparam logic [15:0] LOSE_WORD_DEFAULT = 16'h105E;

    localparam int WIN_COUNT_W = 8;

endpackage

// File: rtl/reel_counter.sv
// One reel: a wrapping digit counter that advances on its strobe unless held.
module reel_counter #(
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic               hold,
    output logic [DIGIT_W-1:0] value
);

    // Synchronous clear wins over counting; hold freezes the current digit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // flop samples pre-edge values, regardless of statement or block order.
        if (clr) begin
            value <= '0;
        end else if (en && !hold) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/slot_reel_game.sv
// N-reel slot/code-lock game core: reel prescaler, in-order stop pointer,
// code compare, tries/lockout tracking and the display word mux.
module slot_reel_game
    import slot_game_pkg::*;
#(
    parameter int N_REELS   = 4,
    parameter int DIGIT_W   = 4,
    parameter int STROBE_W  = 23,
    parameter int MAX_TRIES = 3,
    parameter logic [N_REELS*DIGIT_W-1:0] WIN_WORD  = WIN_WORD_DEFAULT,
    parameter logic [N_REELS*DIGIT_W-1:0] LOSE_WORD = LOSE_WORD_DEFAULT,
    localparam int WORD_W  = N_REELS*DIGIT_W,
    localparam int TRIES_W = $clog2(MAX_TRIES+1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [WORD_W-1:0]      code,
    output logic [WORD_W-1:0]      reels,
    output logic [N_REELS-1:0]     stopped,
    output logic [WORD_W-1:0]      display,
    output logic                   win,
    output logic                   lose,
    output logic                   locked,
    output logic [TRIES_W-1:0]     tries_left,
    output logic [WIN_COUNT_W-1:0] win_count
);

    localparam int PRE_W = STROBE_W + N_REELS;

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [PRE_W-1:0]   prescaler;
    logic [N_REELS-1:0] strobe;
    logic [N_REELS-1:0] stop_hit;
    logic               spinning;
    logic               start_round;
    logic               code_match;
    logic               pre_msb_unused;

    assign spinning    = (state == ST_SPIN);
    assign start_round = start && (state == ST_IDLE || state == ST_WIN || state == ST_LOSE);
    assign code_match  = (reels == code);

    // The prescaler MSB only sets the wrap period; no reel strobe decodes it.
    assign pre_msb_unused = prescaler[PRE_W-1];

    // Stop pointer: one-hot of the lowest reel not yet stopped, only while spinning.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        stop_hit = '0;
        if (spinning && stop) begin
            stop_hit = ~stopped & (stopped + 1'b1);
        end
    end

    // Reel i strobes when the low STROBE_W+i prescaler bits are all ones.
    for (genvar i = 0; i < N_REELS; i++) begin : g_reel
        assign strobe[i] = spinning && (&prescaler[STROBE_W+i-1:0]);

        // A reel being stopped this cycle is held, so its frozen value is the pre-edge one.
        reel_counter #(
            .DIGIT_W (DIGIT_W)
        ) u_reel (
            .clk   (clk),
            .clr   (!reset_n),
            .en    (strobe[i]),
            .hold  (stopped[i] | stop_hit[i]),
            .value (reels[i*DIGIT_W +: DIGIT_W])
        );
    end

    // Next-state logic; start is only honoured in the idle/result states.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) state_next = ST_SPIN;
            end
            ST_SPIN: begin
                if (&(stopped | stop_hit)) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (code_match)                      state_next = ST_WIN;
                else if (tries_left == TRIES_W'(1))  state_next = ST_LOCKED;
                else                                 state_next = ST_LOSE;
            end
            ST_LOCKED: state_next = ST_LOCKED;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Registered state, prescaler, stop flags, counters and status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            prescaler  <= '0;
            stopped    <= '0;
            tries_left <= TRIES_W'(MAX_TRIES);
            win_count  <= '0;
            win        <= 1'b0;
            lose       <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state  <= state_next;
            win    <= (state_next == ST_WIN);
            lose   <= (state_next == ST_LOSE) || (state_next == ST_LOCKED);
            locked <= (state_next == ST_LOCKED);

            if (start_round) begin
                prescaler <= '0;
                stopped   <= '0;
                if (state == ST_WIN) tries_left <= TRIES_W'(MAX_TRIES);
            end else if (spinning) begin
                prescaler <= prescaler + 1'b1;
                stopped   <= stopped | stop_hit;
            end

            if (state == ST_CHECK) begin
                if (code_match) begin
                    if (win_count != '1) win_count <= win_count + 1'b1;
                end else begin
                    tries_left <= tries_left - 1'b1;
                end
            end
        end
    end

    // Display word: live reels until a result is known, then the result word.
    always_comb begin
        display = reels;
        if (state == ST_WIN)                              display = WIN_WORD;
        else if (state == ST_LOSE || state == ST_LOCKED)  display = LOSE_WORD;
    end

endmodule

// File: tb/tb_slot_reel_game.sv
// Directed scoreboard bench for slot_reel_game with a fast prescaler (STROBE_W=2).
module tb_slot_reel_game;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [15:0] code;
    logic [15:0] reels;
    logic [3:0]  stopped;
    logic [15:0] display;
    logic        win;
    logic        lose;
    logic        locked;
    logic [1:0]  tries_left;
    logic [7:0]  win_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    slot_reel_game #(
        .N_REELS   (4),
        .DIGIT_W   (4),
        .STROBE_W  (2),
        .MAX_TRIES (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .code       (code),
        .reels      (reels),
        .stopped    (stopped),
        .display    (display),
        .win        (win),
        .lose       (lose),
        .locked     (locked),
        .tries_left (tries_left),
        .win_count  (win_count)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows.
    task automatic check(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h with no expectation queued", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic push_status(input string step, input logic [15:0] r, input logic [3:0] s,
                               input logic [15:0] d, input logic w, input logic l, input logic k,
                               input logic [1:0] t, input logic [7:0] c);
        push({step, ".reels"}, 32'(r));
        push({step, ".stopped"}, 32'(s));
        push({step, ".display"}, 32'(d));
        push({step, ".win"}, 32'(w));
        push({step, ".lose"}, 32'(l));
        push({step, ".locked"}, 32'(k));
        push({step, ".tries_left"}, 32'(t));
        push({step, ".win_count"}, 32'(c));
    endtask

    task automatic check_status();
        check(32'(reels));
        check(32'(stopped));
        check(32'(display));
        check(32'(win));
        check(32'(lose));
        check(32'(locked));
        check(32'(tries_left));
        check(32'(win_count));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Four stop pulses on consecutive cycles; stopped fills from reel 0 upward.
    task automatic stop_all(input string step, input logic [15:0] r);
        logic [3:0] fill;
        fill = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            fill = {fill[2:0], 1'b1};
            push({step, ".stopped_fill"}, 32'(fill));
            push({step, ".frozen_reels"}, 32'(r));
            stop = 1'b1;
            tick();
            check(32'(stopped));
            check(32'(reels));
        end
        stop = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        code    = 16'h0000;
        tick(2);
        reset_n = 1'b1;

        // Idle after reset: everything at its reset value.
        push_status("reset_idle", 16'h0000, 4'h0, 16'h0000, 0, 0, 0, 2'd3, 8'd0);
        tick(20);
        check_status();

        // Spin: reel0 first steps after 4 cycles; after 64 cycles reels = 2,4,8,0.
        pulse_start();
        push_status("spin4", 16'h0001, 4'h0, 16'h0001, 0, 0, 0, 2'd3, 8'd0);
        tick(4);
        check_status();
        push_status("spin64", 16'h2480, 4'h0, 16'h2480, 0, 0, 0, 2'd3, 8'd0);
        tick(60);
        check_status();

        // Winning round: code equals the frozen reels.
        code = 16'h2480;
        stop_all("win_round", 16'h2480);
        push_status("check_state", 16'h2480, 4'hF, 16'h2480, 0, 0, 0, 2'd3, 8'd0);
        check_status();
        push_status("win_state", 16'h2480, 4'hF, 16'h0BED, 1, 0, 0, 2'd3, 8'd1);
        tick();
        check_status();

        // Round A: stop coinciding with the reel0 strobe, then start+stop together.
        code = 16'h0000;
        pulse_start();
        push_status("roundA_start", 16'h2480, 4'h0, 16'h2480, 0, 0, 0, 2'd3, 8'd1);
        check_status();
        push("roundA_pre_strobe.reels", 32'h2480);
        tick(3);
        check(32'(reels));
        push("stop_on_strobe.reels", 32'h2480);
        push("stop_on_strobe.stopped", 32'h1);
        stop = 1'b1;
        tick();
        check(32'(reels));
        check(32'(stopped));
        push("start_with_stop.stopped", 32'h3);
        push("start_with_stop.display", 32'h2480);
        start = 1'b1;
        tick();
        start = 1'b0;
        check(32'(stopped));
        check(32'(display));
        push("roundA_stop3.stopped", 32'h7);
        tick();
        check(32'(stopped));
        push("roundA_stop4.stopped", 32'hF);
        tick();
        stop = 1'b0;
        check(32'(stopped));
        push_status("roundA_lose", 16'h2480, 4'hF, 16'h105E, 0, 1, 0, 2'd2, 8'd1);
        tick();
        check_status();

        // Round B: spin 8 cycles (reel0 +2, reel1 +1), then lose again.
        pulse_start();
        push("roundB_tries_kept", 32'd2);
        check(32'(tries_left));
        push("roundB_spin8.reels", 32'h2492);
        tick(8);
        check(32'(reels));
        stop_all("roundB", 16'h2492);
        push_status("roundB_lose", 16'h2492, 4'hF, 16'h105E, 0, 1, 0, 2'd1, 8'd1);
        tick(2);
        check_status();

        // Round C: last try fails -> LOCKED.
        pulse_start();
        stop_all("roundC", 16'h2492);
        push_status("locked", 16'h2492, 4'hF, 16'h105E, 0, 1, 1, 2'd0, 8'd1);
        tick(2);
        check_status();

        // LOCKED ignores start and stop.
        pulse_start();
        tick(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        push_status("locked_hold", 16'h2492, 4'hF, 16'h105E, 0, 1, 1, 2'd0, 8'd1);
        tick();
        check_status();

        // Reset leaves LOCKED.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        push_status("unlock_reset", 16'h0000, 4'h0, 16'h0000, 0, 0, 0, 2'd3, 8'd0);
        check_status();

        // Reset mid-SPIN after two stops.
        pulse_start();
        tick(5);
        stop = 1'b1;
        tick(2);
        stop = 1'b0;
        push("mid_spin.stopped", 32'h3);
        push("mid_spin.reels", 32'h0001);
        check(32'(stopped));
        check(32'(reels));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        push_status("mid_spin_reset", 16'h0000, 4'h0, 16'h0000, 0, 0, 0, 2'd3, 8'd0);
        check_status();

        // stop in IDLE is ignored.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        push_status("idle_stop", 16'h0000, 4'h0, 16'h0000, 0, 0, 0, 2'd3, 8'd0);
        tick();
        check_status();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
